// File: rtl/cello_tt_sweeper_if.sv
// rtl/cello_tt_sweeper_if.sv - host/circuit bundle for the Cello truth-table sweeper
interface cello_tt_sweeper_if;
  logic        start;
  logic        abort;
  logic        circ_out;
  logic        in1;
  logic        in2;
  logic        in3;
  logic        in4;
  logic        busy;
  logic        done;
  logic        pass;
  logic [15:0] tt;
  logic [15:0] mismatch;

  modport master (
    output start, abort, circ_out,
    input  in1, in2, in3, in4, busy, done, pass, tt, mismatch
  );

  modport slave (
    input  start, abort, circ_out,
    output in1, in2, in3, in4, busy, done, pass, tt, mismatch
  );
endinterface

// File: rtl/cello_tt_sweeper.sv
// rtl/cello_tt_sweeper.sv - steps a 4-input circuit through all rows and captures its truth table
// CELLO_SWEEP_MAJORITY_EN selects a 2-of-3 majority over three samples per row.
module cello_tt_sweeper #(
  parameter int unsigned SETTLE_CYCLES = 1000,
  parameter logic [15:0] EXPECTED      = 16'h2A56
) (
  input logic               clk,
  input logic               rst_n,
  cello_tt_sweeper_if.slave bus
);

`ifdef CELLO_SWEEP_MAJORITY_EN
  localparam int unsigned NUM_SAMPLES = 3;
`else
  localparam int unsigned NUM_SAMPLES = 1;
`endif
  localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYCLES - 1);
  localparam logic [15:0] SAMPLE_LAST = 16'(NUM_SAMPLES - 1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETTLE = 2'd1;
  localparam logic [1:0] ST_SAMPLE = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [3:0]  k_q, k_d;
  logic [15:0] cnt_q, cnt_d;
  logic [3:0]  row_q, row_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        pass_q, pass_d;
  logic [15:0] tt_q, tt_d;
  logic [15:0] mis_q, mis_d;
  logic [1:0]  sync_q;
  logic        sync_s;
  logic        sample_bit;

  // circ_out is asynchronous; only the second flop is ever observed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], bus.circ_out};
    end
  end

  assign sync_s = sync_q[1];

`ifdef CELLO_SWEEP_MAJORITY_EN
  logic [1:0] smp_q, smp_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      smp_q <= 2'b00;
    end else begin
      smp_q <= smp_d;
    end
  end

  always_comb begin
    smp_d = smp_q;
    if (state_q == ST_SAMPLE) begin
      smp_d = {smp_q[0], sync_s};
    end
  end

  // The final sample of a row votes with the two taken just before it.
  assign sample_bit = (smp_q[1] & smp_q[0]) | (smp_q[1] & sync_s) | (smp_q[0] & sync_s);
`else
  assign sample_bit = sync_s;
`endif

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    cnt_d   = cnt_q;
    row_d   = row_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    pass_d  = pass_q;
    tt_d    = tt_q;
    mis_d   = mis_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.start && !bus.abort) begin
          tt_d    = 16'h0000;
          mis_d   = 16'h0000;
          pass_d  = 1'b0;
          k_d     = 4'd0;
          row_d   = 4'd0;
          cnt_d   = 16'd0;
          busy_d  = 1'b1;
          state_d = ST_SETTLE;
        end
      end

      ST_SETTLE: begin
        if (bus.abort) begin
          row_d   = 4'd0;
          busy_d  = 1'b0;
          pass_d  = 1'b0;
          mis_d   = 16'h0000;
          state_d = ST_IDLE;
        end else if (cnt_q == SETTLE_LAST) begin
          cnt_d   = 16'd0;
          state_d = ST_SAMPLE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end

      ST_SAMPLE: begin
        if (bus.abort) begin
          row_d   = 4'd0;
          busy_d  = 1'b0;
          pass_d  = 1'b0;
          mis_d   = 16'h0000;
          state_d = ST_IDLE;
        end else if (cnt_q == SAMPLE_LAST) begin
          tt_d[k_q] = sample_bit;
          cnt_d     = 16'd0;
          if (k_q == 4'd15) begin
            state_d = ST_DONE;
          end else begin
            // The next row goes out on the same edge that records this one.
            k_d     = k_q + 4'd1;
            row_d   = k_q + 4'd1;
            state_d = ST_SETTLE;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end

      ST_DONE: begin
        done_d  = 1'b1;
        pass_d  = (tt_q == EXPECTED);
        mis_d   = tt_q ^ EXPECTED;
        row_d   = 4'd0;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      k_q     <= 4'd0;
      cnt_q   <= 16'd0;
      row_q   <= 4'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      tt_q    <= 16'h0000;
      mis_q   <= 16'h0000;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      cnt_q   <= cnt_d;
      row_q   <= row_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      tt_q    <= tt_d;
      mis_q   <= mis_d;
    end
  end

  // All four inputs come from one register, so a row change is a single edge.
  assign bus.in2      = row_q[3];
  assign bus.in1      = row_q[2];
  assign bus.in4      = row_q[1];
  assign bus.in3      = row_q[0];
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.pass     = pass_q;
  assign bus.tt       = tt_q;
  assign bus.mismatch = mis_q;

endmodule

// File: tb/tb_cello_tt_sweeper.sv
// tb/tb_cello_tt_sweeper.sv - randomized and directed bench for cello_tt_sweeper with a timeline model
module tb_cello_tt_sweeper;

`ifdef CELLO_SWEEP_MAJORITY_EN
  localparam int S = 3;
`else
  localparam int S = 1;
`endif
  localparam int SA = 4;
  localparam int SB = 8;
  localparam int WA = SA + S;
  localparam int WB = SB + S;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   cyc = 0;
  int   n_pass = 0;
  int   n_total = 0;

  logic [1:0] start_v = 2'b00;
  logic [1:0] abort_v = 2'b00;
  logic [1:0] mode [2];
  logic [1:0] glitch_on = 2'b00;
  int         glitch_lbl [2];
  logic [1:0] rnd_q = 2'b00;
  logic [2:0] gate_sr [2];
  logic [1:0] circ_v;

  logic [1:0]  obs_busy, obs_done, obs_pass;
  logic [3:0]  obs_row [2];
  logic [15:0] obs_tt [2];
  logic [15:0] obs_mis [2];

  cello_tt_sweeper_if ifa ();
  cello_tt_sweeper_if ifb ();

  cello_tt_sweeper #(.SETTLE_CYCLES(SA), .EXPECTED(16'hF0F0)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(ifa)
  );
  cello_tt_sweeper #(.SETTLE_CYCLES(SB)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(ifb)
  );

  always #5 clk = ~clk;

  assign ifa.start = start_v[0];
  assign ifa.abort = abort_v[0];
  assign ifb.start = start_v[1];
  assign ifb.abort = abort_v[1];
  assign ifa.circ_out = circ_v[0];
  assign ifb.circ_out = circ_v[1];

  assign obs_busy = {ifb.busy, ifa.busy};
  assign obs_done = {ifb.done, ifa.done};
  assign obs_pass = {ifb.pass, ifa.pass};
  assign obs_row[0] = {ifa.in2, ifa.in1, ifa.in4, ifa.in3};
  assign obs_row[1] = {ifb.in2, ifb.in1, ifb.in4, ifb.in3};
  assign obs_tt[0] = ifa.tt;
  assign obs_tt[1] = ifb.tt;
  assign obs_mis[0] = ifa.mismatch;
  assign obs_mis[1] = ifb.mismatch;

  function automatic int w_of(input int i);
    return (i == 0) ? WA : WB;
  endfunction

  function automatic logic [15:0] exp_of(input int i);
    return (i == 0) ? 16'hF0F0 : 16'h2A56;
  endfunction

  function automatic logic nor2(input logic a, input logic b);
    return ~(a | b);
  endfunction

  // NOR-only netlist of 0x2A56 over k = {in2, in1, in4, in3}
  function automatic logic gate_f(input logic [3:0] k);
    logic n0, n3, o21n, or21, a21, x1, x2, nh, g0, ng0, t1, t0, o;
    n0   = nor2(k[0], k[0]);
    n3   = nor2(k[3], k[3]);
    o21n = nor2(k[2], k[1]);
    or21 = nor2(o21n, o21n);
    a21  = nor2(nor2(k[2], k[2]), nor2(k[1], k[1]));
    x1   = nor2(k[3], or21);
    x2   = nor2(n3, a21);
    nh   = nor2(x1, x2);
    g0   = nor2(k[3], o21n);
    ng0  = nor2(g0, g0);
    t1   = nor2(n0, nh);
    t0   = nor2(k[0], ng0);
    o    = nor2(t1, t0);
    return nor2(o, o);
  endfunction

  function automatic logic sel_circ(input logic [1:0] m, input logic lb, input logic g,
                                    input logic r);
    case (m)
      2'd1:    return lb;
      2'd2:    return g;
      2'd3:    return r;
      default: return 1'b0;
    endcase
  endfunction

  always @(posedge clk) begin
    cyc <= cyc + 1;
    rnd_q <= 2'($urandom);
    gate_sr[0] <= {gate_sr[0][1:0], gate_f(obs_row[0])};
    gate_sr[1] <= {gate_sr[1][1:0], gate_f(obs_row[1])};
  end

  always_comb begin
    circ_v[0] = sel_circ(mode[0], ifa.in1, gate_sr[0][2], rnd_q[0])
                ^ (glitch_on[0] && cyc == glitch_lbl[0]);
    circ_v[1] = sel_circ(mode[1], ifb.in1, gate_sr[1][2], rnd_q[1])
                ^ (glitch_on[1] && cyc == glitch_lbl[1]);
  end

  // Circuit output as seen during each cycle, indexed by the cycle label.
  bit hist [2][4096];
  always @(negedge clk) begin
    hist[0][cyc & 4095] <= circ_v[0];
    hist[1][cyc & 4095] <= circ_v[1];
  end

  // Row k is decided by the circuit output three cycles before the end of its window.
  function automatic logic [15:0] calc_tt(input int i, input int e0);
    logic [15:0] t;
    int base;
    t = 16'h0000;
    for (int k = 0; k < 16; k++) begin
      base = e0 + (k + 1) * w_of(i) - 3;
`ifdef CELLO_SWEEP_MAJORITY_EN
      t[k] = (hist[i][base & 4095] & hist[i][(base - 1) & 4095])
           | (hist[i][base & 4095] & hist[i][(base - 2) & 4095])
           | (hist[i][(base - 1) & 4095] & hist[i][(base - 2) & 4095]);
`else
      t[k] = hist[i][base & 4095];
`endif
    end
    return t;
  endfunction

  bit        m_run [2];
  int        m_p [2];
  int        m_e0 [2];
  bit        m_done [2];
  bit        m_known [2];
  bit        m_pass [2];
  bit [15:0] m_tt [2];
  bit [15:0] m_mis [2];

  initial begin
    for (int i = 0; i < 2; i++) begin
      m_known[i] = 1'b1;
      mode[i] = 2'd0;
      glitch_lbl[i] = 0;
      gate_sr[i] = 3'b000;
    end
  end

  // p = cycles since the accepted start edge; the sweep spans 16 windows plus one DONE cycle.
  always @(posedge clk or negedge rst_n) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        m_run[i] <= 1'b0;
        m_p[i] <= 0;
        m_done[i] <= 1'b0;
        m_known[i] <= 1'b1;
        m_pass[i] <= 1'b0;
        m_tt[i] <= 16'h0000;
        m_mis[i] <= 16'h0000;
      end else begin
        m_done[i] <= 1'b0;
        if (!m_run[i]) begin
          if (start_v[i] && !abort_v[i]) begin
            m_run[i] <= 1'b1;
            m_p[i] <= 0;
            m_e0[i] <= cyc + 1;
            m_known[i] <= 1'b0;
            m_pass[i] <= 1'b0;
            m_mis[i] <= 16'h0000;
          end
        end else if (m_p[i] < 16 * w_of(i) && abort_v[i]) begin
          m_run[i] <= 1'b0;
          m_known[i] <= 1'b0;
        end else if (m_p[i] == 16 * w_of(i)) begin
          m_run[i] <= 1'b0;
          m_done[i] <= 1'b1;
          m_known[i] <= 1'b1;
          m_tt[i] <= calc_tt(i, m_e0[i]);
          m_pass[i] <= (calc_tt(i, m_e0[i]) == exp_of(i));
          m_mis[i] <= calc_tt(i, m_e0[i]) ^ exp_of(i);
        end else begin
          m_p[i] <= m_p[i] + 1;
        end
      end
    end
  end

  task automatic chk(input string name, input int inst, input logic [31:0] act,
                     input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s[%0d] at cycle %0d: got %h, want %h", name, inst, cyc, act, exp);
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      int r;
      r = m_run[i] ? ((m_p[i] / w_of(i) > 15) ? 15 : m_p[i] / w_of(i)) : 0;
      chk("busy", i, 32'(obs_busy[i]), 32'(m_run[i]));
      chk("row", i, 32'(obs_row[i]), 32'(r));
      chk("done", i, 32'(obs_done[i]), 32'(m_done[i]));
      chk("pass", i, 32'(obs_pass[i]), 32'(m_pass[i]));
      chk("mismatch", i, 32'(obs_mis[i]), 32'(m_mis[i]));
      if (m_known[i]) chk("tt", i, 32'(obs_tt[i]), 32'(m_tt[i]));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start(input logic [1:0] m);
    @(negedge clk);
    start_v = m;
    @(negedge clk);
    start_v = 2'b00;
  endtask

  task automatic wait_done(input int i, input int limit);
    int n;
    n = 0;
    while (!obs_done[i] && n < limit) begin
      @(negedge clk);
      n++;
    end
    chk("done_seen", i, 32'(obs_done[i]), 32'd1);
  endtask

  task automatic wait_idle(input int limit);
    int n;
    n = 0;
    while (obs_busy != 2'b00 && n < limit) begin
      @(negedge clk);
      n++;
    end
    chk("idle_reached", 0, 32'(obs_busy), 32'd0);
  endtask

  task automatic wait_row(input int i, input logic [3:0] r, input int limit);
    int n;
    n = 0;
    while (obs_row[i] != r && n < limit) begin
      @(negedge clk);
      n++;
    end
    chk("row_reached", i, 32'(obs_row[i]), 32'(r));
  endtask

  initial begin
    int na, dcnt;
    #1 rst_n = 1'b0;
    tick(3);
    chk("reset_outputs", 1, {obs_busy, obs_done, obs_pass, obs_row[1], obs_tt[1][7:0]}, 32'd0);
    #2 rst_n = 1'b1;
    tick(3);

    // Loopback on A, NOR gate model on B, both started together.
    mode[0] = 2'd1;
    mode[1] = 2'd2;
    @(negedge clk);
    start_v = 2'b11;
    @(negedge clk);
    start_v = 2'b00;
    na = 1;
    while (!obs_done[0] && na < 2000) begin
      @(negedge clk);
      na++;
    end
    chk("map_latency", 0, 32'(na), 32'(16 * WA + 2));
    chk("map_tt", 0, 32'(obs_tt[0]), 32'h0000F0F0);
    chk("map_pass", 0, 32'(obs_pass[0]), 32'd1);
    chk("map_mismatch", 0, 32'(obs_mis[0]), 32'd0);
    wait_done(1, 400);
    chk("gate_tt", 1, 32'(obs_tt[1]), 32'h00002A56);
    chk("gate_pass", 1, 32'(obs_pass[1]), 32'd1);
    wait_idle(10);

    // Stuck-at-0 circuit.
    mode[0] = 2'd0;
    mode[1] = 2'd0;
    pulse_start(2'b10);
    wait_done(1, 400);
    chk("stuck_tt", 1, 32'(obs_tt[1]), 32'd0);
    chk("stuck_pass", 1, 32'(obs_pass[1]), 32'd0);
    chk("stuck_mismatch", 1, 32'(obs_mis[1]), 32'h00002A56);
    wait_idle(10);

    // Abort during row 5.
    mode[1] = 2'd2;
    pulse_start(2'b10);
    wait_row(1, 4'd5, 400);
    abort_v[1] = 1'b1;
    @(negedge clk);
    abort_v[1] = 1'b0;
    chk("abort_busy", 1, 32'(obs_busy[1]), 32'd0);
    chk("abort_row", 1, 32'(obs_row[1]), 32'd0);
    chk("abort_pass", 1, 32'(obs_pass[1]), 32'd0);
    dcnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (obs_done[1]) dcnt++;
    end
    chk("abort_no_done", 1, 32'(dcnt), 32'd0);

    // Start and abort together in IDLE.
    @(negedge clk);
    start_v[0] = 1'b1;
    abort_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    abort_v[0] = 1'b0;
    chk("start_abort_idle", 0, 32'(obs_busy[0]), 32'd0);

    // Start held high: one sweep per IDLE entry.
    mode[0] = 2'd3;
    @(negedge clk);
    start_v[0] = 1'b1;
    dcnt = 0;
    for (int j = 0; j < 2 * (16 * WA + 2); j++) begin
      @(negedge clk);
      if (obs_done[0]) dcnt++;
    end
    start_v[0] = 1'b0;
    chk("held_done_count", 0, 32'(dcnt), 32'd2);
    wait_idle(10);

    // Randomized starts and aborts.
    mode[0] = 2'd3;
    mode[1] = 2'd2;
    for (int j = 0; j < 1500; j++) begin
      @(negedge clk);
      start_v[0] = ($urandom_range(7) == 0);
      start_v[1] = ($urandom_range(7) == 0);
      abort_v[0] = ($urandom_range(99) == 0);
      abort_v[1] = ($urandom_range(299) == 0);
    end
    start_v = 2'b00;
    abort_v = 2'b00;
    wait_idle(400);

    // Single-cycle glitch on the sampled cycle of row 3.
    mode[1] = 2'd2;
    pulse_start(2'b10);
    glitch_lbl[1] = m_e0[1] + 4 * WB - 3;
    glitch_on[1] = 1'b1;
    wait_done(1, 400);
    glitch_on[1] = 1'b0;
`ifdef CELLO_SWEEP_MAJORITY_EN
    chk("glitch_tt", 1, 32'(obs_tt[1]), 32'h00002A56);
`else
    chk("glitch_tt", 1, 32'(obs_tt[1]), 32'h00002A5E);
`endif
    wait_idle(10);

    // Reset at row 7, then a full clean sweep.
    pulse_start(2'b11);
    wait_row(1, 4'd7, 400);
    #2 rst_n = 1'b0;
    #1;
    chk("midreset_outputs", 1,
        {obs_busy, obs_done, obs_pass, obs_row[1], obs_tt[1][7:0], obs_mis[1][7:0]}, 32'd0);
    chk("midreset_tt", 1, 32'(obs_tt[1]), 32'd0);
    tick(2);
    #2 rst_n = 1'b1;
    tick(2);
    pulse_start(2'b10);
    wait_done(1, 400);
    chk("after_reset_tt", 1, 32'(obs_tt[1]), 32'h00002A56);
    chk("after_reset_pass", 1, 32'(obs_pass[1]), 32'd1);
    tick(3);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
